// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch stage for the MIPS pipeline.
// Produces the next-PC value for ProgramCounter, requests instructions over a
// ready handshake, parks an instruction when ID stalls, and flushes on
// branch/jump redirects (draining any access that is still outstanding).
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCResult,
    output logic [31:0] Address,
    output logic        IReq,
    output logic [31:0] IAddr,
    input  logic        IReady,
    input  logic [31:0] IData,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    output logic [31:0] IF_Instr,
    output logic [31:0] IF_PCPlus4,
    output logic        IF_Valid
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_instr_buf;
    logic [31:0] r_buf_pc;
    logic [31:0] r_req_addr;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pcplus4;
    logic        r_if_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic [31:0] w_pc_plus4;
    logic [1:0]  w_next_state;
    logic [31:0] w_address;
    logic        w_ireq;
    logic [31:0] w_iaddr;
    logic        w_if_load;
    logic        w_if_bubble;
    logic [31:0] w_load_instr;
    logic [31:0] w_load_pcplus4;
    logic        w_buf_load;
    logic        w_req_load;

    // The branch resolves in EX and is older than an ID jump, so it wins.
    assign w_redirect = BranchTaken | JumpTaken;
    assign w_target   = BranchTaken ? BranchTarget : JumpTarget;
    assign w_pc_plus4 = PCResult + 32'd4;  // wraps modulo 2^32

    // Next-state, next-PC and IF/ID update decisions.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        w_next_state   = r_state;
        w_address      = PCResult;
        w_ireq         = 1'b0;
        w_iaddr        = PCResult;
        w_if_load      = 1'b0;
        w_if_bubble    = 1'b0;
        w_load_instr   = IData;
        w_load_pcplus4 = w_pc_plus4;
        w_buf_load     = 1'b0;
        w_req_load     = 1'b0;

        case (r_state)
            S_BOOT: begin
                w_address    = RESET_PC;
                w_next_state = S_FETCH;
            end
            S_FETCH: begin
                w_ireq     = 1'b1;
                w_req_load = 1'b1;
                if (IReady && !Stall) begin
                    w_if_load = 1'b1;
                    w_address = w_pc_plus4;
                end else if (IReady) begin
                    // Data arrived but ID is stalled: park it so the request can retire.
                    w_buf_load   = 1'b1;
                    w_next_state = S_HOLD;
                end else if (!Stall) begin
                    w_if_bubble = 1'b1;
                end
            end
            S_HOLD: begin
                if (!Stall) begin
                    w_if_load      = 1'b1;
                    w_load_instr   = r_instr_buf;
                    w_load_pcplus4 = r_buf_pc + 32'd4;
                    w_address      = w_pc_plus4;
                    w_next_state   = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Keep the abandoned request stable until memory answers, then drop its data.
                w_ireq  = 1'b1;
                w_iaddr = r_req_addr;
                if (IReady) begin
                    w_next_state = S_FETCH;
                end
            end
            default: begin
                w_next_state = S_BOOT;
            end
        endcase

        // A redirect flushes IF/ID and drops any parked instruction; Stall is ignored.
        if (w_redirect && (r_state != S_BOOT)) begin
            w_address   = w_target;
            w_if_load   = 1'b0;
            w_if_bubble = 1'b1;
            w_buf_load  = 1'b0;
            if (!IReady && ((r_state == S_FETCH) || (r_state == S_DRAIN))) begin
                w_next_state = S_DRAIN;
            end else begin
                w_next_state = S_FETCH;
            end
        end
    end

    // State register and the address of the request currently on the bus.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
            r_state    <= S_BOOT;
            r_req_addr <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (w_req_load) begin
                r_req_addr <= PCResult;
            end
        end
    end

    // Hold buffer for an instruction that arrived while ID was stalled.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            // NOTE: the hold buffer is a couple of plain registers, so it is reset like any other state.
            r_instr_buf <= NOP;
            r_buf_pc    <= 32'd0;
        end else if (w_buf_load) begin
            r_instr_buf <= IData;
            r_buf_pc    <= PCResult;
        end
    end

    // IF/ID pipeline register: load, insert a bubble, or hold.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_if_instr   <= NOP;
            r_if_pcplus4 <= 32'd0;
            r_if_valid   <= 1'b0;
        end else if (w_if_load) begin
            r_if_instr   <= w_load_instr;
            r_if_pcplus4 <= w_load_pcplus4;
            r_if_valid   <= 1'b1;
        end else if (w_if_bubble) begin
            r_if_instr <= NOP;
            r_if_valid <= 1'b0;
        end
    end

    assign Address    = w_address;
    assign IReq       = w_ireq;
    assign IAddr      = w_iaddr;
    assign IF_Instr   = r_if_instr;
    assign IF_PCPlus4 = r_if_pcplus4;
    assign IF_Valid   = r_if_valid;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios plus a randomized run
// checked against an in-order delivery model of the instruction stream.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic [31:0] address;
    logic        ireq;
    logic [31:0] iaddr;
    logic        iready;
    logic [31:0] idata;
    logic        stall;
    logic        bt;
    logic [31:0] btarget;
    logic        jt;
    logic [31:0] jtarget;
    logic [31:0] if_instr;
    logic [31:0] if_pcplus4;
    logic        if_valid;

    int total = 0;
    int bad   = 0;

    fetch_sequencer dut (
        .Clk(clk), .Reset(rst_n), .PCResult(pc), .Address(address),
        .IReq(ireq), .IAddr(iaddr), .IReady(iready), .IData(idata),
        .Stall(stall), .BranchTaken(bt), .BranchTarget(btarget),
        .JumpTaken(jt), .JumpTarget(jtarget), .IF_Instr(if_instr),
        .IF_PCPlus4(if_pcplus4), .IF_Valid(if_valid)
    );

    always #5 clk = ~clk;

    // ProgramCounter model: registers Address every edge, resets to 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 32'd0;
        else        pc <= address;
    end

    // Instruction memory contents: a distinct word per address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
    endfunction

    assign idata = iready ? mem_word(iaddr) : 32'hDEAD_BEEF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; iready = 1'b0; stall = 1'b0;
        bt = 1'b0; jt = 1'b0; btarget = 32'd0; jtarget = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Run sequential fetches (iready=1, no stall) until the PC reaches target.
    task automatic advance_to(input logic [31:0] target);
        int n;
        n = 0;
        iready = 1'b1; stall = 1'b0;
        step();
        while (pc != target && n < 200) begin
            step();
            n++;
        end
        total++;
        if (pc != target) begin
            bad++;
            $display("FAIL advance_timeout: pc=%h want %h", pc, target);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iready = 1'b1; stall = 1'b0;
        bt = 1'b0; jt = 1'b0; btarget = 32'd0; jtarget = 32'd0;
        #3;
        total++;
        if (ireq !== 1'b0 || address !== 32'd0 || if_instr !== 32'd0 ||
            if_pcplus4 !== 32'd0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_values: ireq=%b addr=%h instr=%h pc4=%h valid=%b want 0", ireq, address, if_instr, if_pcplus4, if_valid);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        iready = 1'b1;
        #1;
        total++;
        if (ireq !== 1'b0 || address !== 32'd0) begin
            bad++;
            $display("FAIL boot_outputs: ireq=%b addr=%h want 0/0", ireq, address);
        end
        step();
        total++;
        if (ireq !== 1'b1 || iaddr !== 32'd0 || address !== 32'd4) begin
            bad++;
            $display("FAIL first_fetch: ireq=%b iaddr=%h addr=%h want 1/0/4", ireq, iaddr, address);
        end
        for (int k = 1; k <= 4; k++) begin
            step();
            total++;
            if (if_valid !== 1'b1 || if_pcplus4 !== 32'(4 * k) ||
                if_instr !== mem_word(32'(4 * (k - 1))) || address !== 32'(4 * k + 4)) begin
                bad++;
                $display("FAIL seq_%0d: valid=%b pc4=%h instr=%h addr=%h want pc4=%h addr=%h",
                         k, if_valid, if_pcplus4, if_instr, address, 4 * k, 4 * k + 4);
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        advance_to(32'h8);
        iready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (ireq !== 1'b1 || iaddr !== 32'h8 || address !== 32'h8) begin
                bad++;
                $display("FAIL wait_req_%0d: ireq=%b iaddr=%h addr=%h want 1/8/8", i, ireq, iaddr, address);
            end
            step();
            total++;
            if (if_valid !== 1'b0 || if_instr !== 32'd0) begin
                bad++;
                $display("FAIL wait_bubble_%0d: valid=%b instr=%h want 0/0", i, if_valid, if_instr);
            end
        end
        iready = 1'b1;
        #1;
        total++;
        if (ireq !== 1'b1 || iaddr !== 32'h8 || address !== 32'hC) begin
            bad++;
            $display("FAIL wait_ready: ireq=%b iaddr=%h addr=%h want 1/8/c", ireq, iaddr, address);
        end
        step();
        total++;
        if (if_valid !== 1'b1 || if_pcplus4 !== 32'hC || if_instr !== mem_word(32'h8)) begin
            bad++;
            $display("FAIL wait_deliver: valid=%b pc4=%h instr=%h want pc4=c", if_valid, if_pcplus4, if_instr);
        end
    endtask

    task automatic test_stall();
        do_reset();
        advance_to(32'h10);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (address !== 32'h10 || (i > 0 && ireq !== 1'b0)) begin
                bad++;
                $display("FAIL stall_addr_%0d: addr=%h ireq=%b want 10", i, address, ireq);
            end
            step();
            total++;
            if (if_valid !== 1'b1 || if_pcplus4 !== 32'h10 || if_instr !== mem_word(32'hC)) begin
                bad++;
                $display("FAIL stall_frozen_%0d: valid=%b pc4=%h instr=%h want pc4=10", i, if_valid, if_pcplus4, if_instr);
            end
        end
        stall = 1'b0;
        #1;
        total++;
        if (ireq !== 1'b0 || address !== 32'h14) begin
            bad++;
            $display("FAIL stall_release_addr: ireq=%b addr=%h want 0/14", ireq, address);
        end
        step();
        total++;
        if (if_valid !== 1'b1 || if_pcplus4 !== 32'h14 || if_instr !== mem_word(32'h10)) begin
            bad++;
            $display("FAIL stall_release: valid=%b pc4=%h instr=%h want pc4=14", if_valid, if_pcplus4, if_instr);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        advance_to(32'h18);
        bt = 1'b1; btarget = 32'h40;
        #1;
        total++;
        if (address !== 32'h40) begin
            bad++;
            $display("FAIL branch_addr: addr=%h want 40", address);
        end
        step();
        bt = 1'b0;
        total++;
        if (if_valid !== 1'b0 || if_instr !== 32'd0) begin
            bad++;
            $display("FAIL branch_flush: valid=%b instr=%h want 0/0", if_valid, if_instr);
        end
        step();
        total++;
        if (if_valid !== 1'b1 || if_pcplus4 !== 32'h44 || if_instr !== mem_word(32'h40)) begin
            bad++;
            $display("FAIL branch_target: valid=%b pc4=%h want 44", if_valid, if_pcplus4);
        end
        bt = 1'b1; btarget = 32'h40; jt = 1'b1; jtarget = 32'h80;
        #1;
        total++;
        if (address !== 32'h40) begin
            bad++;
            $display("FAIL both_priority: addr=%h want 40", address);
        end
        step();
        bt = 1'b0; jt = 1'b0;
        step();
        total++;
        if (if_pcplus4 !== 32'h44 || if_valid !== 1'b1) begin
            bad++;
            $display("FAIL both_target: pc4=%h valid=%b want 44", if_pcplus4, if_valid);
        end
        jt = 1'b1; jtarget = 32'h80;
        #1;
        total++;
        if (address !== 32'h80) begin
            bad++;
            $display("FAIL jump_addr: addr=%h want 80", address);
        end
        step();
        jt = 1'b0;
        step();
        total++;
        if (if_pcplus4 !== 32'h84 || if_instr !== mem_word(32'h80)) begin
            bad++;
            $display("FAIL jump_target: pc4=%h want 84", if_pcplus4);
        end
    endtask

    task automatic test_redirect_outstanding();
        do_reset();
        advance_to(32'h20);
        iready = 1'b0;
        step();
        bt = 1'b1; btarget = 32'h100;
        #1;
        total++;
        if (address !== 32'h100 || iaddr !== 32'h20 || ireq !== 1'b1) begin
            bad++;
            $display("FAIL drain_redirect: addr=%h iaddr=%h ireq=%b want 100/20/1", address, iaddr, ireq);
        end
        step();
        bt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) iready = 1'b1;
            #1;
            total++;
            if (ireq !== 1'b1 || iaddr !== 32'h20 || if_valid !== 1'b0 || address !== 32'h100) begin
                bad++;
                $display("FAIL drain_hold_%0d: ireq=%b iaddr=%h valid=%b addr=%h want 1/20/0/100", i, ireq, iaddr, if_valid, address);
            end
            step();
        end
        total++;
        if (if_valid !== 1'b0 || iaddr !== 32'h100 || ireq !== 1'b1) begin
            bad++;
            $display("FAIL drain_discard: valid=%b iaddr=%h ireq=%b want 0/100/1", if_valid, iaddr, ireq);
        end
        step();
        total++;
        if (if_valid !== 1'b1 || if_pcplus4 !== 32'h104 || if_instr !== mem_word(32'h100)) begin
            bad++;
            $display("FAIL drain_target: valid=%b pc4=%h instr=%h want pc4=104", if_valid, if_pcplus4, if_instr);
        end
    endtask

    task automatic test_wrap_and_reset();
        do_reset();
        advance_to(32'h8);
        jt = 1'b1; jtarget = 32'hFFFF_FFFC;
        step();
        jt = 1'b0;
        #1;
        total++;
        if (pc !== 32'hFFFF_FFFC || address !== 32'h0) begin
            bad++;
            $display("FAIL wrap_addr: pc=%h addr=%h want fffffffc/0", pc, address);
        end
        step();
        total++;
        if (if_valid !== 1'b1 || if_pcplus4 !== 32'h0 || if_instr !== mem_word(32'hFFFF_FFFC)) begin
            bad++;
            $display("FAIL wrap_deliver: valid=%b pc4=%h want 0", if_valid, if_pcplus4);
        end
        advance_to(32'h8);
        stall = 1'b1;
        step();
        total++;
        if (ireq !== 1'b0 || if_valid !== 1'b1 || if_pcplus4 !== 32'h8 || address !== 32'h8) begin
            bad++;
            $display("FAIL hold_entry: ireq=%b valid=%b pc4=%h addr=%h want 0/1/8/8", ireq, if_valid, if_pcplus4, address);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (ireq !== 1'b0 || address !== 32'd0 || if_instr !== 32'd0 ||
            if_pcplus4 !== 32'd0 || if_valid !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: ireq=%b addr=%h instr=%h pc4=%h valid=%b want 0", ireq, address, if_instr, if_pcplus4, if_valid);
        end
        stall = 1'b0;
    endtask

    // Random handshake, stall and redirect traffic. The model only knows the
    // program order: every instruction ID accepts must be the next one after
    // the last redirect target, fetched from the right address, exactly once.
    task automatic test_random();
        logic [31:0] expected_next;
        logic [31:0] p_instr, p_pc4, p_iaddr, p_tgt, wait_addr;
        logic        p_valid, p_ireq, p_iready, p_stall, p_redir, had_wait;
        int          delivered;
        do_reset();
        iready = 1'b1;
        step();
        expected_next = 32'd4;
        had_wait = 1'b0; wait_addr = 32'd0; delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            iready  = ($urandom_range(0, 2) != 0);
            stall   = ($urandom_range(0, 3) == 0);
            p_redir = ($urandom_range(0, 11) == 0);
            bt      = p_redir && ($urandom_range(0, 1) == 1);
            jt      = p_redir && (!bt || ($urandom_range(0, 1) == 1));
            btarget = 32'($urandom_range(0, 1023)) << 2;
            jtarget = 32'($urandom_range(0, 1023)) << 2;
            p_tgt   = bt ? btarget : jtarget;
            #1;
            p_valid = if_valid; p_instr = if_instr; p_pc4 = if_pcplus4;
            p_ireq = ireq; p_iaddr = iaddr; p_iready = iready; p_stall = stall;
            if (p_redir) begin
                total++;
                if (address !== p_tgt) begin
                    bad++;
                    $display("FAIL rnd_redirect_addr cyc=%0d: addr=%h want %h", cyc, address, p_tgt);
                end
            end
            if (had_wait) begin
                total++;
                if (ireq !== 1'b1 || iaddr !== wait_addr) begin
                    bad++;
                    $display("FAIL rnd_req_stable cyc=%0d: ireq=%b iaddr=%h want 1/%h", cyc, ireq, iaddr, wait_addr);
                end
            end
            if (!if_valid) begin
                total++;
                if (if_instr !== 32'd0) begin
                    bad++;
                    $display("FAIL rnd_bubble_nop cyc=%0d: instr=%h want 0", cyc, if_instr);
                end
            end
            step();
            bt = 1'b0; jt = 1'b0;
            if (p_redir) begin
                total++;
                if (if_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL rnd_flush cyc=%0d: valid=%b want 0", cyc, if_valid);
                end
                expected_next = p_tgt + 32'd4;
            end else if (p_stall) begin
                total++;
                if (if_valid !== p_valid || if_instr !== p_instr || if_pcplus4 !== p_pc4) begin
                    bad++;
                    $display("FAIL rnd_stall_hold cyc=%0d: valid=%b pc4=%h want %b/%h", cyc, if_valid, if_pcplus4, p_valid, p_pc4);
                end
            end else if (p_valid) begin
                total++;
                if (p_pc4 !== expected_next || p_instr !== mem_word(p_pc4 - 32'd4)) begin
                    bad++;
                    $display("FAIL rnd_order cyc=%0d: pc4=%h instr=%h want pc4=%h", cyc, p_pc4, p_instr, expected_next);
                end
                expected_next = expected_next + 32'd4;
                delivered++;
            end
            had_wait  = p_ireq && !p_iready;
            wait_addr = p_iaddr;
        end
        total++;
        if (delivered < 200) begin
            bad++;
            $display("FAIL rnd_progress: delivered=%0d want >= 200", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wait_states();
        test_stall();
        test_redirect();
        test_redirect_outstanding();
        test_wrap_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer for the MIPS pipeline: the producer of the `Address` input that the ProgramCounter registers and the consumer of its `PCResult`. It requests each instruction from instruction memory over a ready handshake, absorbs wait states and pipeline stalls, applies branch/jump redirects with flush, and drives the registered IF/ID outputs.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `NOP`, 32'h0000_0000: instruction word driven on `IF_Instr` when the stage is empty.

- `Clk`  in  1  rising-edge clock.
- `Reset`  in  1  asynchronous, active-low reset.
- `PCResult`  in  32  current PC from ProgramCounter.
- `Address`  out  32  next-PC value to ProgramCounter (combinational).
- `IReq`  out  1  instruction-memory request.
- `IAddr`  out  32  instruction-memory address.
- `IReady`  in  1  memory has `IData` valid this cycle.
- `IData`  in  32  instruction word.
- `Stall`  in  1  hazard unit: hold the IF/ID register.
- `BranchTaken`  in  1  one-cycle pulse, EX-resolved branch.
- `BranchTarget`  in  32  branch target.
- `JumpTaken`  in  1  one-cycle pulse, ID-resolved jump.
- `JumpTarget`  in  32  jump target.
- `IF_Instr`  out  32  registered instruction to ID.
- `IF_PCPlus4`  out  32  registered PC+4 of `IF_Instr`.
- `IF_Valid`  out  1  `IF_Instr` is a real instruction.

## Operation
- States: BOOT, FETCH, HOLD, DRAIN. Reset enters BOOT.
- Internal registers: `InstrBuf`/`BufPC` (hold buffer) and `ReqAddr` (outstanding address).
- `redirect` = `BranchTaken | JumpTaken`. Redirect target: `BranchTarget` if `BranchTaken`, otherwise `JumpTarget`. The branch is older, so it wins when both are asserted.
- BOOT:
  - `IReq`=0, `Address`=`RESET_PC`.
  - Next state is FETCH unconditionally, including when `redirect` is asserted in BOOT (the redirect is ignored).
- FETCH:
  - `IReq`=1, `IAddr`=`PCResult`, `ReqAddr`<=`PCResult` on every edge.
  - `IReady & !Stall` (advance): IF regs <= {`IData`, `PCResult`+4, 1}; `Address`=`PCResult`+4.
  - `IReady & Stall`: `InstrBuf`<=`IData`, `BufPC`<=`PCResult`; go to HOLD; `Address`=`PCResult`; IF regs hold.
  - `!IReady & !Stall`: `IF_Valid`<=0, `IF_Instr`<=`NOP` (bubble); `Address`=`PCResult`.
  - `!IReady & Stall`: IF regs hold; `Address`=`PCResult`.
- HOLD:
  - `IReq`=0.
  - `!Stall`: IF regs <= {`InstrBuf`, `BufPC`+4, 1}; `Address`=`PCResult`+4; go to FETCH.
  - `Stall`: everything holds.
- DRAIN:
  - `IReq`=1, `IAddr`=`ReqAddr`; `IData` is discarded.
  - `Address`=`PCResult`, which already holds the redirect target.
  - Go to FETCH on `IReady`.
- Redirect (any state except BOOT) overrides everything above:
  - `Address`=target.
  - `IF_Valid`<=0, `IF_Instr`<=`NOP`; `Stall` is ignored.
  - Any buffered instruction is dropped.
  - Next state: DRAIN if in FETCH with `!IReady` or already in DRAIN with `!IReady`; otherwise FETCH.
- Arithmetic: `PCResult`+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0.

## Timing
- Reset asserted (async):
  - State = BOOT, `IReq`=0, `Address`=`RESET_PC`.
  - `IF_Instr`=`NOP`, `IF_PCPlus4`=0, `IF_Valid`=0.
  - `InstrBuf`=`NOP`, `BufPC`=0, `ReqAddr`=0.
- Reset asserted mid-access abandons the outstanding request. Memory must tolerate a dropped `IReq`.
- Zero-wait memory (`IReady` the same cycle as `IReq`):
  - One instruction per cycle.
  - `IF_Valid` rises on the 2nd rising edge after reset release (1 BOOT cycle + 1 FETCH cycle).
- N wait states give N bubble cycles per instruction.
- The redirect is seen by ProgramCounter on the next edge. The first target instruction reaches IF/ID after 1 cycle + memory latency (+ drain time if an access was outstanding).
- `IReq`/`IAddr` are stable from assertion until `IReady`.

## Test plan
- **Sequential fetch:** Reset release with `RESET_PC`=0, `IReady`=1 tied, no stall.
  - Required: `IF_PCPlus4` = 4, 8, 12, 16 on consecutive cycles with `IF_Valid`=1.
  - Required: `Address` = 4, 8, 12… one cycle ahead.
- **Wait states:** `IReady` low for 2 cycles on the fetch at 0x8.
  - Required: `IAddr` holds 0x8 and `IReq`=1 for 3 cycles.
  - Required: 2 bubbles (`IF_Valid`=0, `IF_Instr`=`NOP`), then `IF_PCPlus4`=0xC.
- **Stall with data:** `Stall`=1 for 3 cycles while `IReady`=1 at PC 0x10.
  - Required: IF regs frozen, state HOLD, `Address`=0x10.
  - Required: on release, `IF_Instr` = word from 0x10 and `IF_PCPlus4`=0x14.
- **Redirect:**
  - `BranchTaken` with target 0x40 at PC 0x18: `Address`=0x40 that cycle, `IF_Valid`=0 next cycle, then `IF_PCPlus4`=0x44.
  - Simultaneous `JumpTaken`(0x80) and `BranchTaken`(0x40): branch wins, `Address`=0x40.
- **Redirect during outstanding access:** branch to 0x100 while the fetch at 0x20 is waiting.
  - Required: `IAddr` stays 0x20 until `IReady`; that data is discarded.
  - Required: next `IAddr`=0x100; `IF_PCPlus4`=0x104.
- **Wrap and reset:**
  - `PCResult`=0xFFFF_FFFC with `IReady`=1: `Address`=0x0.
  - `Reset` low mid-HOLD: all outputs reach their reset values immediately, without waiting for a clock edge.
